entropy_collector: RTL and testbench
====================================

// Module: entropy_collector
// PURPOSE
//  Consumer side of the TRNG health-test interface. Drives the health-test enable and samples raw noise bits.
//  Acts on the per-sample error flag and the total-failure flag.
//  Runs a start-up qualification, then packs healthy raw bits into WORD_W-bit words on a valid/ready stream.
//  Raises a sticky alarm on total failure. Sits between the ring-oscillator/health-test pair and the bus-side FIFO.
// PARAMETERS
//  WORD_W          32    output word width in bits (>=2)
//  STARTUP_SAMPLES 1024  consecutive error-free samples required before COLLECT (>=1)
//  DROP_CNT_W      16    width of saturating dropped-word counter
// PORTS
//  clk                 in   1          system clock, all logic posedge
//  rst_i               in   1          asynchronous active-high reset
//  enable_i            in   1          collector enable; low -> IDLE
//  rnd_bit_i           in   1          raw noise bit
//  rnd_valid_i         in   1          rnd_bit_i qualifier, one sample per cycle max
//  ht_error_i          in   1          health-test error for the current sample (same cycle as rnd_bit_i)
//  ht_total_failure_i  in   1          health-test total-failure flag
//  ht_enable_o         out  1          enable to health test
//  word_o              out  WORD_W     packed entropy word
//  word_valid_o        out  1          word_o valid
//  word_ready_i        in   1          downstream accept
//  alarm_o             out  1          sticky total-failure alarm
//  clear_alarm_i       in   1          alarm clear request
//  state_o             out  2          current FSM state (trng_pkg::ec_state_e)
//  dropped_cnt_o       out  DROP_CNT_W words lost to backpressure, saturating
// BEHAVIOUR
//  Reset values: state IDLE, all outputs 0, shift register and bit counter cleared.
//  A sample is taken only on a cycle with rnd_valid_i=1 in STARTUP or COLLECT.
//  FSM:
//   IDLE    -> STARTUP when enable_i=1; ht_enable_o=0 only in IDLE.
//   STARTUP -> counts samples. ht_error_i=1 on a sample restarts the count at 0.
//            -> COLLECT on the cycle after the STARTUP_SAMPLES-th clean sample.
//            -> Startup samples are never packed.
//   COLLECT -> shifts sample into LSB of packer and increments bit count.
//            -> ht_error_i=1 on a sample discards the sample and the partial word (count -> 0); no state change.
//   any(!IDLE) -> FAULT when ht_total_failure_i=1; alarm_o=1 the next cycle.
//            -> Pending word_valid_o is cleared and the word discarded.
//   FAULT   -> IDLE when clear_alarm_i=1 and ht_total_failure_i=0; alarm_o cleared the same edge.
//            -> clear_alarm_i while failure is still asserted is ignored.
//   enable_i=0 in STARTUP/COLLECT -> IDLE next cycle. The partial word is flushed.
//            -> A pending output word stays valid until accepted.
//  Priority on the same cycle: total failure > enable_i=0 > ht_error_i > normal sample.
//  Output: single holding register. A word completes on the cycle the WORD_W-th bit is sampled.
//   -> word_o/word_valid_o update on the next edge (1-cycle latency).
//   -> Handshake completes on valid&&ready. word_o is stable while valid&&!ready.
//   -> Completion while valid&&!ready: new word dropped, dropped_cnt_o += 1 (saturates at all-ones).
//   -> Completion with valid&&ready in the same cycle: new word loaded, word_valid_o stays 1.
//  Reset asserted mid-word or mid-handshake: immediate return to the reset values, with no partial output.
// CONFIGURATION
//  ENTROPY_COLLECTOR_XOR_FOLD_EN defined: COLLECT consumes raw bit pairs. The first bit is held.
//   -> The second bit's XOR with the first is packed as one bit, so a word needs 2*WORD_W clean samples.
//   -> ht_error_i on either bit of a pair discards the pair and the partial word.
//   -> STARTUP is unchanged.
//  Not defined: each clean raw bit is packed directly, and there is no pair state.
// STRUCTURE
//  trng_pkg: typedef enum logic [1:0] ec_state_e {EC_IDLE=0, EC_STARTUP=1, EC_COLLECT=2, EC_FAULT=3}.
//   -> trng_pkg also holds the shared STARTUP_SAMPLES default constant.
//  Sub-module bit_packer: shift register, bit counter, done strobe, and flush input.
//   -> Its flush input covers both the ht_error_i discard and the enable_i=0 flush.
//   -> Instantiated once.
//  FSM, holding register and drop counter stay in the top.
// TESTING
//  1. WORD_W=8, STARTUP_SAMPLES=4, enable_i=1, 4 clean samples
//     -> state_o goes IDLE->STARTUP->COLLECT; no word_valid_o.
//  2. Then bits 1,0,1,1,0,0,1,0 with word_ready_i=1 -> word_o=8'hB2, word_valid_o high for 1 cycle.
//  3. ht_error_i on the 5th bit of a word, then 8 more clean bits
//     -> exactly one word, built from the post-error bits only.
//  4. word_ready_i=0 while 3 words complete -> first word held stable, dropped_cnt_o=2.
//  5. ht_total_failure_i=1 in COLLECT with a pending word -> word_valid_o=0, alarm_o=1, state FAULT.
//     -> clear_alarm_i with failure still high: no change. After failure drops, clear -> IDLE, alarm_o=0.
//  6. XOR_FOLD_EN: raw pairs 10,11,01,00 ... -> packed bits 1,0,1,0; rst_i pulsed mid-word -> all outputs 0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared TRNG types and constants used by the entropy collector.
package trng_pkg;

  typedef enum logic [1:0] {
    EC_IDLE    = 2'd0,
    EC_STARTUP = 2'd1,
    EC_COLLECT = 2'd2,
    EC_FAULT   = 2'd3
  } ec_state_e;

  localparam int EC_STARTUP_SAMPLES_DEF = 1024;

endpackage

// File: rtl/bit_packer.sv
// Serial-to-parallel packer: MSB-first shift, bit counter, done strobe on the last bit.
module bit_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_shift,
  input  logic              i_bit,
  input  logic              i_flush,
  output logic [WORD_W-1:0] o_word,
  output logic              o_done
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-2:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == CNT_W'(WORD_W - 1));
  // The completed word includes the bit being sampled this cycle.
  assign o_word = {r_sr, i_bit};
  assign o_done = i_shift && !i_flush && w_last;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_flush || o_done) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr  <= o_word[WORD_W-2:0];
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// TRNG entropy collector: start-up qualification, word packing, holding register, sticky alarm.
// Optional ENTROPY_COLLECTOR_XOR_FOLD_EN packs the XOR of raw bit pairs instead of raw bits.
module entropy_collector
  import trng_pkg::*;
#(
  parameter int WORD_W          = 32,
  parameter int STARTUP_SAMPLES = EC_STARTUP_SAMPLES_DEF,
  parameter int DROP_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  rnd_bit_i,
  input  logic                  rnd_valid_i,
  input  logic                  ht_error_i,
  input  logic                  ht_total_failure_i,
  output logic                  ht_enable_o,
  output logic [WORD_W-1:0]     word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  alarm_o,
  input  logic                  clear_alarm_i,
  output logic [1:0]            state_o,
  output logic [DROP_CNT_W-1:0] dropped_cnt_o
);

  localparam int SU_W = $clog2(STARTUP_SAMPLES + 1);

  ec_state_e             r_state;
  logic [SU_W-1:0]       r_su_cnt;
  logic                  r_alarm;
  logic                  r_valid;
  logic [WORD_W-1:0]     r_word;
  logic [DROP_CNT_W-1:0] r_drop;

  logic              w_active, w_fail_hit, w_disable, w_col_sample, w_pack_err;
  logic              w_shift, w_bit, w_flush, w_done;
  logic [WORD_W-1:0] w_word;

  // Priority: total failure > disable > health error > normal sample.
  assign w_active     = (r_state == EC_STARTUP) || (r_state == EC_COLLECT);
  assign w_fail_hit   = w_active && ht_total_failure_i;
  assign w_disable    = w_active && !ht_total_failure_i && !enable_i;
  assign w_col_sample = (r_state == EC_COLLECT) && !ht_total_failure_i && enable_i && rnd_valid_i;
  assign w_pack_err   = w_col_sample && ht_error_i;
  assign w_flush      = w_fail_hit || w_disable || w_pack_err;

`ifdef ENTROPY_COLLECTOR_XOR_FOLD_EN
  logic r_have;
  logic r_first;

  assign w_shift = w_col_sample && !ht_error_i && r_have;
  assign w_bit   = r_first ^ rnd_bit_i;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_have  <= 1'b0;
      r_first <= 1'b0;
    end else if (w_flush) begin
      r_have  <= 1'b0;
    end else if (w_col_sample) begin
      r_have  <= !r_have;
      if (!r_have) r_first <= rnd_bit_i;
    end
  end
`else
  assign w_shift = w_col_sample && !ht_error_i;
  assign w_bit   = rnd_bit_i;
`endif

  bit_packer #(.WORD_W(WORD_W)) u_packer (
    .clk     (clk),
    .i_rst   (rst_i),
    .i_shift (w_shift),
    .i_bit   (w_bit),
    .i_flush (w_flush),
    .o_word  (w_word),
    .o_done  (w_done)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= EC_IDLE;
      r_su_cnt <= '0;
      r_alarm  <= 1'b0;
      r_valid  <= 1'b0;
      r_word   <= '0;
      r_drop   <= '0;
    end else begin
      if (w_fail_hit) begin
        r_state <= EC_FAULT;
        r_alarm <= 1'b1;
      end else if (w_disable) begin
        r_state <= EC_IDLE;
      end else begin
        case (r_state)
          EC_IDLE: if (enable_i) begin
            r_state  <= EC_STARTUP;
            r_su_cnt <= '0;
          end
          EC_STARTUP: if (rnd_valid_i) begin
            if (ht_error_i)                                  r_su_cnt <= '0;
            else if (r_su_cnt == SU_W'(STARTUP_SAMPLES - 1)) r_state  <= EC_COLLECT;
            else                                             r_su_cnt <= r_su_cnt + SU_W'(1);
          end
          EC_FAULT: if (clear_alarm_i && !ht_total_failure_i) begin
            r_state <= EC_IDLE;
            r_alarm <= 1'b0;
          end
          default: ;
        endcase
      end

      // Single holding register; a word completing into a stalled slot is dropped.
      if (w_fail_hit) begin
        r_valid <= 1'b0;
      end else if (w_done) begin
        if (!r_valid || word_ready_i) begin
          r_word  <= w_word;
          r_valid <= 1'b1;
        end else if (!(&r_drop)) begin
          r_drop <= r_drop + DROP_CNT_W'(1);
        end
      end else if (r_valid && word_ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign ht_enable_o   = (r_state != EC_IDLE);
  assign state_o       = r_state;
  assign alarm_o       = r_alarm;
  assign word_valid_o  = r_valid;
  assign word_o        = r_word;
  assign dropped_cnt_o = r_drop;

endmodule

// File: tb/tb_entropy_collector.sv
// Directed bench for entropy_collector with a cycle-level behavioural model and literal checks.
module tb_entropy_collector;

  localparam int W = 8;
  localparam int N = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          enable_i = 1'b0;
  logic          rnd_bit_i = 1'b0;
  logic          rnd_valid_i = 1'b0;
  logic          ht_error_i = 1'b0;
  logic          ht_total_failure_i = 1'b0;
  logic          ht_enable_o;
  logic [W-1:0]  word_o;
  logic          word_valid_o;
  logic          word_ready_i = 1'b0;
  logic          alarm_o;
  logic          clear_alarm_i = 1'b0;
  logic [1:0]    state_o;
  logic [DW-1:0] dropped_cnt_o;

  int errors = 0;
  int checks = 0;

  entropy_collector #(.WORD_W(W), .STARTUP_SAMPLES(N), .DROP_CNT_W(DW)) dut (
    .clk                (clk),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .rnd_bit_i          (rnd_bit_i),
    .rnd_valid_i        (rnd_valid_i),
    .ht_error_i         (ht_error_i),
    .ht_total_failure_i (ht_total_failure_i),
    .ht_enable_o        (ht_enable_o),
    .word_o             (word_o),
    .word_valid_o       (word_valid_o),
    .word_ready_i       (word_ready_i),
    .alarm_o            (alarm_o),
    .clear_alarm_i      (clear_alarm_i),
    .state_o            (state_o),
    .dropped_cnt_o      (dropped_cnt_o)
  );

  always #5 clk = ~clk;

  // Behavioural model: state as 0..3, partial word as integer accumulator.
  int m_state = 0, m_cnt = 0, m_nb = 0, m_acc = 0, m_word = 0, m_drop = 0;
  bit m_valid = 0, m_alarm = 0, m_have = 0, m_first = 0;

  always @(posedge clk or posedge rst_i) begin : model
    int st, cnt, nb, acc, outw, drp, nw, pb;
    bit vld, alm, have, first, done, do_pack;
    if (rst_i) begin
      m_state <= 0; m_cnt <= 0; m_nb <= 0; m_acc <= 0; m_word <= 0; m_drop <= 0;
      m_valid <= 0; m_alarm <= 0; m_have <= 0; m_first <= 0;
    end else begin
      st = m_state; cnt = m_cnt; nb = m_nb; acc = m_acc; outw = m_word; drp = m_drop;
      vld = m_valid; alm = m_alarm; have = m_have; first = m_first;
      done = 0; do_pack = 0; nw = 0; pb = 0;
      if ((st == 1 || st == 2) && ht_total_failure_i) begin
        st = 3; alm = 1; vld = 0; nb = 0; acc = 0; have = 0;
      end else if ((st == 1 || st == 2) && !enable_i) begin
        st = 0; nb = 0; acc = 0; have = 0;
      end else if (st == 0) begin
        if (enable_i) begin st = 1; cnt = 0; end
      end else if (st == 3) begin
        if (clear_alarm_i && !ht_total_failure_i) begin st = 0; alm = 0; end
      end else if (rnd_valid_i) begin
        if (st == 1) begin
          if (ht_error_i) cnt = 0;
          else begin cnt = cnt + 1; if (cnt == N) st = 2; end
        end else if (ht_error_i) begin
          nb = 0; acc = 0; have = 0;
        end else begin
`ifdef ENTROPY_COLLECTOR_XOR_FOLD_EN
          if (!have) begin have = 1; first = rnd_bit_i; end
          else begin have = 0; do_pack = 1; pb = int'(first ^ rnd_bit_i); end
`else
          do_pack = 1; pb = int'(rnd_bit_i);
`endif
        end
      end
      if (do_pack) begin
        acc = (acc * 2 + pb) % (1 << W);
        nb = nb + 1;
        if (nb == W) begin done = 1; nw = acc; nb = 0; acc = 0; end
      end
      if (done) begin
        if (!vld || word_ready_i) begin vld = 1; outw = nw; end
        else if (drp < (1 << DW) - 1) drp = drp + 1;
      end else if (vld && word_ready_i) begin
        vld = 0;
      end
      m_state <= st; m_cnt <= cnt; m_nb <= nb; m_acc <= acc; m_word <= outw; m_drop <= drp;
      m_valid <= vld; m_alarm <= alm; m_have <= have; m_first <= first;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("mdl_state", 32'(state_o), 32'(m_state));
    check("mdl_ht_en", 32'(ht_enable_o), 32'(m_state != 0));
    check("mdl_valid", 32'(word_valid_o), 32'(m_valid));
    check("mdl_alarm", 32'(alarm_o), 32'(m_alarm));
    check("mdl_drop", 32'(dropped_cnt_o), 32'(m_drop));
    if (m_valid) check("mdl_word", 32'(word_o), 32'(m_word));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sample(input logic b, input logic e);
    rnd_valid_i = 1'b1; rnd_bit_i = b; ht_error_i = e;
    tick();
    rnd_valid_i = 1'b0; ht_error_i = 1'b0;
  endtask

  // One packed bit: a raw bit, or a (0,b) pair when folding.
  task automatic send_bit(input logic b, input logic e);
`ifdef ENTROPY_COLLECTOR_XOR_FOLD_EN
    if (e) sample(1'b0, 1'b1);
    else begin sample(1'b0, 1'b0); sample(b, 1'b0); end
`else
    sample(b, e);
`endif
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  task automatic startup();
    for (int i = 0; i < N; i++) sample(1'b1, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    repeat (3) tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_valid", 32'(word_valid_o), 32'd0);
    check("rst_alarm", 32'(alarm_o), 32'd0);
    check("rst_drop", 32'(dropped_cnt_o), 32'd0);
    check("rst_word", 32'(word_o), 32'd0);
    check("rst_ht_en", 32'(ht_enable_o), 32'd0);
    rst_i = 1'b0;
    tick();

    enable_i = 1'b1; word_ready_i = 1'b1;
    tick();
    check("t1_startup", 32'(state_o), 32'd1);
    check("t1_ht_en", 32'(ht_enable_o), 32'd1);
    startup();
    check("t1_collect", 32'(state_o), 32'd2);
    check("t1_novalid", 32'(word_valid_o), 32'd0);

    send_byte(8'hB2);
    check("t2_valid", 32'(word_valid_o), 32'd1);
    check("t2_word", 32'(word_o), 32'hB2);
    tick();
    check("t2_accepted", 32'(word_valid_o), 32'd0);

    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_byte(8'h55);
    check("t3_valid", 32'(word_valid_o), 32'd1);
    check("t3_word", 32'(word_o), 32'h55);
    tick();

    word_ready_i = 1'b0;
    send_byte(8'hA5);
    check("t4_first_word", 32'(word_o), 32'hA5);
    send_byte(8'h0F);
    send_byte(8'hF0);
    check("t4_held_word", 32'(word_o), 32'hA5);
    check("t4_held_valid", 32'(word_valid_o), 32'd1);
    check("t4_dropped", 32'(dropped_cnt_o), 32'd2);

    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    ht_total_failure_i = 1'b1;
    tick();
    check("t5_fault", 32'(state_o), 32'd3);
    check("t5_alarm", 32'(alarm_o), 32'd1);
    check("t5_killed", 32'(word_valid_o), 32'd0);
    clear_alarm_i = 1'b1;
    tick();
    check("t5_clr_ignored", 32'(state_o), 32'd3);
    check("t5_alarm_held", 32'(alarm_o), 32'd1);
    clear_alarm_i = 1'b0; ht_total_failure_i = 1'b0;
    tick();
    check("t5_sticky", 32'(alarm_o), 32'd1);
    clear_alarm_i = 1'b1;
    tick();
    check("t5_idle", 32'(state_o), 32'd0);
    check("t5_alarm_clr", 32'(alarm_o), 32'd0);
    clear_alarm_i = 1'b0;

    word_ready_i = 1'b1;
    tick();
    startup();
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    enable_i = 1'b0;
    tick();
    check("t6_dis_idle", 32'(state_o), 32'd0);
    check("t6_dis_ht_en", 32'(ht_enable_o), 32'd0);
    enable_i = 1'b1;
    tick();
    startup();
    send_byte(8'h3C);
    check("t6_flushed_word", 32'(word_o), 32'h3C);
    tick();

    word_ready_i = 1'b0;
    send_byte(8'h81);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    rst_i = 1'b1;
    #1;
    check("t7_rst_state", 32'(state_o), 32'd0);
    check("t7_rst_valid", 32'(word_valid_o), 32'd0);
    check("t7_rst_word", 32'(word_o), 32'd0);
    check("t7_rst_drop", 32'(dropped_cnt_o), 32'd0);
    tick();
    rst_i = 1'b0; word_ready_i = 1'b1;
    tick();
    tick();
    startup();
    send_byte(8'hC3);
    check("t7_clean_word", 32'(word_o), 32'hC3);
    tick();

`ifdef ENTROPY_COLLECTOR_XOR_FOLD_EN
    for (int r = 0; r < 2; r++) begin
      sample(1'b1, 1'b0); sample(1'b0, 1'b0);
      sample(1'b1, 1'b0); sample(1'b1, 1'b0);
      sample(1'b0, 1'b0); sample(1'b1, 1'b0);
      sample(1'b0, 1'b0); sample(1'b0, 1'b0);
    end
    check("t8_xor_word", 32'(word_o), 32'hAA);
    check("t8_xor_valid", 32'(word_valid_o), 32'd1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
